// File: rtl/rng_pkg.sv
// Shared widths, the repetition-count counter width and elaboration-time
// parameter checks for the TRNG word pool.
package rng_pkg;

    localparam int DEFAULT_OUTPUT_WIDTH = 16;
    localparam int DEFAULT_TRNG_WIDTH   = 4;
    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_RCT_CUTOFF   = 8;
    localparam int RCT_CNT_W            = 8;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic bit width_ok(input int output_width, input int trng_width);
        return (trng_width > 0) && (output_width % trng_width == 0) &&
               (output_width / trng_width >= 2);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit cutoff_ok(input int cutoff);
        return (cutoff >= 2) && (cutoff <= 255);
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// First-word-fall-through word FIFO with synchronous flush; the head entry
// is always presented on head, and count/full/empty are registered-derived.
module rng_fifo
    import rng_pkg::*;
#(
    parameter int WIDTH = DEFAULT_OUTPUT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is cleared on reset so no stale random word
    // from before a reset can ever reach the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rng_word_pool.sv
// Packs TRNG chunks MSB-first into output words, buffers them in a FIFO and
// runs a repetition-count health test that flushes everything on failure.
module rng_word_pool
    import rng_pkg::*;
#(
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
    parameter int TRNG_WIDTH   = DEFAULT_TRNG_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int RCT_CUTOFF   = DEFAULT_RCT_CUTOFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [TRNG_WIDTH-1:0]   trng_word,
    input  logic                    trng_valid,
    output logic                    trng_req,
    input  logic                    health_clr,
    output logic [OUTPUT_WIDTH-1:0] random_word,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [clog2(DEPTH):0]   fill_level,
    output logic                    health_fail
);

    localparam int N   = OUTPUT_WIDTH / TRNG_WIDTH;
    localparam int K_W = clog2(N);
    localparam int SW  = OUTPUT_WIDTH - TRNG_WIDTH;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    if (!width_ok(OUTPUT_WIDTH, TRNG_WIDTH)) begin : g_bad_width
        $error("OUTPUT_WIDTH must be a multiple of TRNG_WIDTH with at least two chunks");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (!cutoff_ok(RCT_CUTOFF)) begin : g_bad_cutoff
        $error("RCT_CUTOFF must lie in 2..255");
    end

    logic [K_W-1:0]          k;
    logic [SW-1:0]           shift;
    logic [TRNG_WIDTH-1:0]   last_chunk;
    logic [RCT_CNT_W-1:0]    rep_cnt;
    logic [RCT_CNT_W-1:0]    rep_next;
    logic [OUTPUT_WIDTH-1:0] word_next;
    logic                    at_last;
    logic                    accept;
    logic                    trip;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [OUTPUT_WIDTH-1:0] fifo_head;

    assign at_last   = (k == K_LAST);
    assign trng_req  = en && !health_fail && !(fifo_full && at_last);
    assign accept    = trng_valid && trng_req;
    assign word_next = {shift, trng_word};

    // rep_cnt == 0 means no chunk has been seen since reset or clear.
    assign rep_next = (rep_cnt != '0 && trng_word == last_chunk) ?
                      rep_cnt + RCT_CNT_W'(1) : RCT_CNT_W'(1);

    // A clear on the same edge wins, so the chunk is neither tested nor packed.
    assign trip = accept && !health_clr && (rep_next == RCT_CNT_W'(RCT_CUTOFF));
    assign push = accept && !health_clr && at_last && !trip;

    assign output_valid = !fifo_empty && !health_fail;
    assign pop          = output_valid && output_ready;
    assign random_word  = output_valid ? fifo_head : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            k           <= '0;
            shift       <= '0;
            last_chunk  <= '0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
        end else if (health_clr) begin
            k           <= '0;
            shift       <= '0;
            last_chunk  <= '0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
        end else if (trip) begin
            k           <= '0;
            shift       <= '0;
            last_chunk  <= trng_word;
            rep_cnt     <= rep_next;
            health_fail <= 1'b1;
        end else if (accept) begin
            last_chunk <= trng_word;
            rep_cnt    <= rep_next;
            if (at_last) begin
                k     <= '0;
                shift <= '0;
            end else begin
                k     <= k + K_W'(1);
                shift <= word_next[SW-1:0];
            end
        end
    end

    rng_fifo #(
        .WIDTH (OUTPUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (trip),
        .push      (push),
        .push_data (word_next),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fill_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_rng_word_pool.sv
// Directed and randomized checks of rng_word_pool against a queue-based
// behavioural model of chunk packing, FIFO buffering and the health test.
module tb_rng_word_pool;

    localparam int OW  = 16;
    localparam int TW  = 4;
    localparam int DP  = 4;
    localparam int CUT = 8;
    localparam int N   = OW / TW;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [TW-1:0] trng_word;
    logic          trng_valid;
    logic          trng_req;
    logic          health_clr;
    logic [OW-1:0] random_word;
    logic          output_valid;
    logic          output_ready;
    logic [2:0]    fill_level;
    logic          health_fail;

    int tests = 0;
    int fails = 0;

    logic [TW-1:0] m_part[$];
    logic [OW-1:0] m_words[$];
    logic [TW-1:0] m_last;
    int            m_rep;
    bit            m_fail;

    rng_word_pool #(
        .OUTPUT_WIDTH (OW),
        .TRNG_WIDTH   (TW),
        .DEPTH        (DP),
        .RCT_CUTOFF   (CUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .trng_word    (trng_word),
        .trng_valid   (trng_valid),
        .trng_req     (trng_req),
        .health_clr   (health_clr),
        .random_word  (random_word),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .fill_level   (fill_level),
        .health_fail  (health_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic bit model_req();
        return en && !m_fail && !(m_words.size() == DP && m_part.size() == N - 1);
    endfunction

    function automatic bit model_valid();
        return (m_words.size() > 0) && !m_fail;
    endfunction

    task automatic compare_all();
        check("trng_req", 32'(trng_req), 32'(model_req()));
        check("output_valid", 32'(output_valid), 32'(model_valid()));
        check("random_word", 32'(random_word), model_valid() ? 32'(m_words[0]) : 32'h0);
        check("fill_level", 32'(fill_level), 32'(m_words.size()));
        check("health_fail", 32'(health_fail), 32'(m_fail));
    endtask

    // Drive one cycle of inputs from a negedge, update the model at the
    // posedge, then compare at the following negedge.
    task automatic step(input logic e, input logic v, input logic [TW-1:0] w,
                        input logic rdy, input logic clr, input logic rst);
        bit req;
        bit valid;
        bit acc;
        logic [OW-1:0] word;
        en = e; trng_valid = v; trng_word = w;
        output_ready = rdy; health_clr = clr; reset = rst;
        req   = model_req();
        valid = model_valid();
        @(posedge clk);
        if (rst) begin
            m_part.delete(); m_words.delete();
            m_last = '0; m_rep = 0; m_fail = 1'b0;
        end else if (clr) begin
            if (valid && rdy) void'(m_words.pop_front());
            m_part.delete();
            m_last = '0; m_rep = 0; m_fail = 1'b0;
        end else begin
            acc = v && req;
            if (valid && rdy) void'(m_words.pop_front());
            if (acc) begin
                m_rep  = (m_rep != 0 && w == m_last) ? m_rep + 1 : 1;
                m_last = w;
                if (m_rep == CUT) begin
                    m_fail = 1'b1;
                    m_part.delete();
                    m_words.delete();
                end else begin
                    m_part.push_back(w);
                    if (m_part.size() == N) begin
                        word = '0;
                        foreach (m_part[i]) word = (word << TW) | OW'(m_part[i]);
                        m_words.push_back(word);
                        m_part.delete();
                    end
                end
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic feed(input logic [TW-1:0] w, input logic rdy);
        step(1'b1, 1'b1, w, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [OW-1:0] exp_words[4];
        logic [TW-1:0] prev_w;
        logic [TW-1:0] w;
        int bias;

        reset = 1'b1; en = 1'b0; trng_valid = 1'b0; trng_word = '0;
        output_ready = 1'b0; health_clr = 1'b0;
        m_last = '0; m_rep = 0; m_fail = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("reset_req", 32'(trng_req), 32'h0);
        check("reset_valid", 32'(output_valid), 32'h0);
        check("reset_fill", 32'(fill_level), 32'h0);

        // Basic assembly: one word visible for exactly one cycle.
        for (int i = 1; i <= 4; i++) feed(TW'(i), 1'b1);
        check("basic_word", 32'(random_word), 32'h1234);
        check("basic_valid", 32'(output_valid), 32'h1);
        idle(1'b1);
        check("basic_one_cycle", 32'(output_valid), 32'h0);

        // Backpressure: fill all four entries, then stall with k at the last chunk.
        for (int i = 0; i < 16; i++) feed(TW'(i), 1'b0);
        check("bp_full", 32'(fill_level), 32'h4);
        for (int i = 1; i <= 3; i++) feed(TW'(i), 1'b0);
        check("bp_stall_req", 32'(trng_req), 32'h0);
        feed(4'h4, 1'b0);
        check("bp_still_stalled", 32'(trng_req), 32'h0);
        check("bp_head0", 32'(random_word), 32'h0123);
        idle(1'b1);
        check("bp_req_resumes", 32'(trng_req), 32'h1);
        feed(4'h4, 1'b0);
        exp_words = '{16'h4567, 16'h89AB, 16'hCDEF, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            check("bp_order", 32'(random_word), 32'(exp_words[i]));
            idle(1'b1);
        end
        check("bp_drained", 32'(fill_level), 32'h0);

        // en gap holds the partial word.
        feed(4'h5, 1'b1);
        feed(4'h6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
            check("gap_req", 32'(trng_req), 32'h0);
        end
        feed(4'h7, 1'b1);
        feed(4'h8, 1'b1);
        check("gap_word", 32'(random_word), 32'h5678);
        idle(1'b1);

        // Health failure flushes buffered words; clear resumes packing.
        for (int i = 1; i <= 8; i++) feed(TW'(i), 1'b0);
        check("hf_two_words", 32'(fill_level), 32'h2);
        for (int i = 0; i < CUT; i++) feed(4'hA, 1'b0);
        check("hf_fail", 32'(health_fail), 32'h1);
        check("hf_valid", 32'(output_valid), 32'h0);
        check("hf_fill", 32'(fill_level), 32'h0);
        check("hf_req", 32'(trng_req), 32'h0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("hf_cleared", 32'(health_fail), 32'h0);
        feed(4'h9, 1'b1);
        feed(4'hA, 1'b1);
        feed(4'hB, 1'b1);
        feed(4'hC, 1'b1);
        check("hf_resume_word", 32'(random_word), 32'h9ABC);
        idle(1'b1);

        // Simultaneous push and pop at fill level 2.
        for (int i = 1; i <= 8; i++) feed(TW'(i), 1'b0);
        feed(4'h9, 1'b0);
        feed(4'hA, 1'b0);
        feed(4'hB, 1'b0);
        feed(4'hC, 1'b1);
        check("pp_fill", 32'(fill_level), 32'h2);
        check("pp_head", 32'(random_word), 32'h5678);
        idle(1'b1);
        check("pp_next", 32'(random_word), 32'h9ABC);
        idle(1'b1);

        // Reset mid-word discards the partial chunks.
        feed(4'h1, 1'b0);
        feed(4'h2, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_word", 32'(random_word), 32'h0);
        check("rst_req", 32'(trng_req), 32'h1);
        feed(4'hF, 1'b1);
        feed(4'hE, 1'b1);
        feed(4'hD, 1'b1);
        feed(4'hC, 1'b1);
        check("rst_new_word", 32'(random_word), 32'hFEDC);

        // Randomized traffic, alternating low- and high-repetition segments.
        prev_w = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bias = ((cyc / 250) % 2 == 1) ? 95 : 10;
            if ($urandom_range(99) < bias) w = prev_w;
            else w = TW'($urandom);
            prev_w = w;
            step(($urandom_range(9) != 0),
                 ($urandom_range(9) < 7),
                 w,
                 ($urandom_range(9) < 6),
                 (m_fail ? ($urandom_range(19) == 0) : ($urandom_range(99) == 0)),
                 ($urandom_range(499) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
